// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, control bundle and defaults for the pipeline sequencer
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        ERR   = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic en_F;
        logic en_D;
        logic en_E;
        logic en_M;
        logic en_W;
        logic clr_D;
        logic clr_E;
        logic clr_W;
    } pipe_ctrl_t;

    localparam int DWAIT_MAX_DEF = 255;
    localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/pipe_wdog.sv
// pipe_wdog: counts consecutive data-memory wait cycles and flags the timeout limit
module pipe_wdog
    import pipe_pkg::*;
#(
    parameter int DWAIT_MAX = DWAIT_MAX_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cnt_en_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of consecutive wait cycles, cleared as soon as the wait ends
    always_comb cnt_d = !cnt_en_i ? '0 : (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // A >= compare keeps DWAIT_MAX=1 reachable once the FSM is in DWAIT
    assign expire_o = cnt_en_i && (cnt_q >= CNT_W'(DWAIT_MAX - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline enable/clear sequencer with wrong-path kill and d-mem watchdog; PIPE_CTRL_PERF_EN adds stall counters
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DWAIT_MAX = DWAIT_MAX_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hz_stallF,
    input  logic hz_stallD,
    input  logic hz_flushD,
    input  logic hz_flushE,
    input  logic br_en_E,
    input  logic imem_valid,
    input  logic dmem_req_M,
    input  logic dmem_ack,
    output logic en_F,
    output logic en_D,
    output logic en_E,
    output logic en_M,
    output logic en_W,
    output logic clr_D,
    output logic clr_E,
    output logic clr_W,
    output logic halted,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] perf_dstall,
    output logic [CNT_W-1:0] perf_istall,
    output logic [CNT_W-1:0] perf_hstall,
`endif
    output logic timeout_err
);

    pipe_state_e state_q, state_d;
    logic        kill_q, kill_d, tmo_q, tmo_d;
    logic        dwait, err, expire, live, consume, set_kill;
    pipe_ctrl_t  ctl;

    assign dwait = dmem_req_M & ~dmem_ack;
    assign err   = state_q == ERR;
    // Hazard-driven decisions only matter when neither halted nor frozen on d-mem
    assign live  = ~err & ~dwait;
    // A valid fetch while a kill is pending is the wrong-path instruction: bubble it
    assign consume  = live & ~hz_stallD & kill_q & imem_valid;
    assign set_kill = live & br_en_E & (~imem_valid | kill_q);

    pipe_wdog #(
        .DWAIT_MAX (DWAIT_MAX),
        .CNT_W     (CNT_W)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_en_i (dwait & ~err),
        .expire_o (expire)
    );

    // Priority-ordered enable/clear decision
    always_comb begin
        ctl = '{en_F: 1'b1, en_D: 1'b1, en_E: 1'b1, en_M: 1'b1, en_W: 1'b1,
                clr_D: 1'b0, clr_E: 1'b0, clr_W: 1'b0};
        if (err) begin
            ctl = '0;
        end else if (dwait) begin
            ctl       = '0;
            ctl.en_W  = 1'b1;
            ctl.clr_W = 1'b1;
        end else if (hz_stallD) begin
            ctl.en_F  = ~(hz_stallF | hz_stallD);
            ctl.en_D  = 1'b0;
            ctl.clr_E = 1'b1;
            ctl.clr_D = hz_flushD;
        end else if (hz_flushD | hz_flushE) begin
            ctl.clr_D = hz_flushD;
            ctl.clr_E = hz_flushE;
        end else if (!imem_valid) begin
            ctl.en_F  = 1'b0;
            ctl.clr_D = 1'b1;
        end
        ctl.clr_D = ctl.clr_D | consume;
    end

    assign {en_F, en_D, en_E, en_M, en_W, clr_D, clr_E, clr_W} = ctl;
    assign halted      = err;
    assign timeout_err = tmo_q;

    // FSM, sticky timeout and kill tracker next state
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        if (state_q == RUN && dwait) begin
            state_d = DWAIT;
        end else if (state_q == DWAIT && expire) begin
            state_d = ERR;
            tmo_d   = 1'b1;
        end else if (state_q == DWAIT && !dwait) begin
            state_d = RUN;
        end
        kill_d = set_kill ? 1'b1 : consume ? 1'b0 : kill_q;
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            kill_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] pd_q, pi_q, ph_q;
    logic             inc_d, inc_i, inc_h;

    assign inc_d = ~err & dwait;
    assign inc_i = live & ~hz_stallD & ~hz_flushD & ~hz_flushE & ~imem_valid;
    assign inc_h = live & hz_stallD;

    // Saturating stall counters; all increment enables are low in ERR
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pd_q <= '0;
            pi_q <= '0;
            ph_q <= '0;
        end else begin
            if (inc_d && !(&pd_q)) pd_q <= pd_q + CNT_W'(1);
            if (inc_i && !(&pi_q)) pi_q <= pi_q + CNT_W'(1);
            if (inc_h && !(&ph_q)) ph_q <= ph_q + CNT_W'(1);
        end
    end

    assign perf_dstall = pd_q;
    assign perf_istall = pi_q;
    assign perf_hstall = ph_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (DWAIT_MAX=4)
module tb_pipe_ctrl;
    import pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, hz_stallF, hz_stallD, hz_flushD, hz_flushE, br_en_E, imem_valid, dmem_req_M, dmem_ack;
    logic en_F, en_D, en_E, en_M, en_W, clr_D, clr_E, clr_W, halted, timeout_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] perf_dstall, perf_istall, perf_hstall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipe_ctrl #(.DWAIT_MAX(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .hz_stallF(hz_stallF), .hz_stallD(hz_stallD), .hz_flushD(hz_flushD), .hz_flushE(hz_flushE),
        .br_en_E(br_en_E), .imem_valid(imem_valid), .dmem_req_M(dmem_req_M), .dmem_ack(dmem_ack),
        .en_F(en_F), .en_D(en_D), .en_E(en_E), .en_M(en_M), .en_W(en_W),
        .clr_D(clr_D), .clr_E(clr_E), .clr_W(clr_W), .halted(halted),
`ifdef PIPE_CTRL_PERF_EN
        .perf_dstall(perf_dstall), .perf_istall(perf_istall), .perf_hstall(perf_hstall),
`endif
        .timeout_err(timeout_err)
    );

    // {halted, timeout_err, en_F, en_D, en_E, en_M, en_W, clr_D, clr_E, clr_W}
    wire [9:0] obs = {halted, timeout_err, en_F, en_D, en_E, en_M, en_W, clr_D, clr_E, clr_W};

    localparam logic [9:0] O_RUN  = 10'b00_11111_000;
    localparam logic [9:0] O_DW   = 10'b00_00001_001;
    localparam logic [9:0] O_LU   = 10'b00_00111_010;
    localparam logic [9:0] O_LUF  = 10'b00_00111_110;
    localparam logic [9:0] O_BR   = 10'b00_11111_110;
    localparam logic [9:0] O_IW   = 10'b00_01111_100;
    localparam logic [9:0] O_KILL = 10'b00_11111_100;
    localparam logic [9:0] O_ERR  = 10'b11_00000_000;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic sf, sd, fd, fe, br, iv, rq, ak);
        {hz_stallF, hz_stallD, hz_flushD, hz_flushE, br_en_E, imem_valid, dmem_req_M, dmem_ack} =
            {sf, sd, fd, fe, br, iv, rq, ak};
    endtask

    task automatic cyc(input string tag, input logic [9:0] exp);
        #2;
        chk(tag, 16'(obs), 16'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 1, 1, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_state", 16'(dut.state_q), 16'(RUN));
        rst_n = 1'b1;
        cyc("rst_release", O_DW);
        chk("rst_to_dwait", 16'(dut.state_q), 16'(DWAIT));
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        cyc("idle", O_RUN);

        drv(0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc("dmem_wait", O_DW);
        drv(0, 0, 0, 0, 0, 1, 1, 1);
        cyc("dmem_ack", O_RUN);
        chk("dmem_back_run", 16'(dut.state_q), 16'(RUN));

        drv(1, 1, 0, 1, 0, 1, 0, 0);
        cyc("load_use", O_LU);
        drv(1, 1, 1, 0, 0, 1, 0, 0);
        cyc("load_use_flushD", O_LUF);
        drv(1, 1, 0, 1, 0, 1, 1, 0);
        cyc("load_use_dwait", O_DW);
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        cyc("post_lu", O_RUN);

        drv(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("fetch_wait", O_IW);
        chk("no_kill", 16'(dut.kill_q), 16'd0);

        drv(0, 0, 1, 1, 1, 0, 0, 0);
        cyc("kill_br1", O_BR);
        chk("kill_set", 16'(dut.kill_q), 16'd1);
        cyc("kill_br2", O_BR);
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        cyc("kill_consume", O_KILL);
        chk("kill_clear", 16'(dut.kill_q), 16'd0);
        cyc("kill_after", O_RUN);

        drv(0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc("wdog_wait", O_DW);
        chk("wdog_err_state", 16'(dut.state_q), 16'(ERR));
        drv(1, 1, 1, 1, 1, 1, 0, 0);
        cyc("err_hold1", O_ERR);
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        cyc("err_hold2", O_ERR);
        do_reset();
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        cyc("err_reset", O_RUN);

        drv(0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc("wdog2_wait", O_DW);
        drv(0, 0, 0, 0, 0, 1, 1, 1);
        cyc("wdog2_ack_limit", O_RUN);
        chk("wdog2_run", 16'(dut.state_q), 16'(RUN));
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        cyc("wdog2_after", O_RUN);

`ifdef PIPE_CTRL_PERF_EN
        do_reset();
        drv(0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc("perf_dw_a", O_DW);
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        cyc("perf_gap1", O_RUN);
        drv(0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 2; i++) cyc("perf_dw_b", O_DW);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) cyc("perf_iw", O_IW);
        drv(1, 1, 0, 0, 0, 1, 0, 0);
        cyc("perf_lu", O_LU);
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        cyc("perf_gap2", O_RUN);
        chk("perf_dstall", perf_dstall, 16'd5);
        chk("perf_istall", perf_istall, 16'd2);
        chk("perf_hstall", perf_hstall, 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencer for the 5-stage RV32I pipeline.
- Merges hazard-unit stall/flush requests with instruction- and data-memory wait handshakes.
- Drives one enable and one clear per pipeline register (F, D, E, M, W).
- Adds a wrong-path fetch-kill tracker and a data-memory watchdog that halts the core on a hung bus.

Parameters:
- DWAIT_MAX, 255, consecutive data-memory wait cycles before timeout (1..65535).
- CNT_W, 16, width of the wait counter and perf counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- hz_stallF  in  1  hazard-unit fetch stall
- hz_stallD  in  1  hazard-unit decode stall
- hz_flushD  in  1  hazard-unit decode flush
- hz_flushE  in  1  hazard-unit execute flush
- br_en_E  in  1  branch/jump taken in E
- imem_valid  in  1  fetch data valid this cycle
- dmem_req_M  in  1  load/store present in M
- dmem_ack  in  1  data memory completes M access this cycle
- en_F, en_D, en_E, en_M, en_W  out  1 each  pipeline register enables (en_F is the PC enable)
- clr_D, clr_E, clr_W  out  1 each  synchronous bubble insert into D/E/W register
- halted  out  1  core halted (ERR state)
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- One clock. Reset is synchronous and active-low: clk, rst_n.
- Reset takes effect on the rising clk edge with rst_n=0:
  - state=RUN, wait_cnt=0, kill_pending=0, timeout_err=0, halted=0.
- Outputs are combinational from state plus inputs.
- States: RUN, DWAIT, ERR.
- dwait = dmem_req_M & ~dmem_ack.
- Decision priority, highest first:
  1. ERR: all en_*=0, all clr_*=0, halted=1. Only reset exits.
  2. dwait: en_F=en_D=en_E=en_M=0, en_W=1, clr_W=1.
     - Hazard flush/stall inputs are ignored this cycle. The frozen stages re-present them on release.
  3. hz_stallD (load-use): en_F=en_D=0, en_E=1, clr_E=1, en_M=en_W=1.
     - hz_flushD still applies (clr_D=1).
  4. hz_flushD/hz_flushE (branch): all en_*=1, clr_D=hz_flushD, clr_E=hz_flushE.
  5. ~imem_valid: en_F=0, en_D=1, clr_D=1; E/M/W advance.
  6. Otherwise: all en_*=1, all clr_*=0.
- Combination of rules 4 and 5: when ~imem_valid and br_en_E hold together, the flush is applied and kill_pending is set to 1 (the fetch in flight is wrong-path).
- kill_pending behaviour:
  - While kill_pending=1, the first cycle with imem_valid=1 forces clr_D=1 and en_F=1, then clears kill_pending.
  - Another br_en_E while kill_pending=1 keeps it at 1.
- FSM transitions:
  - RUN→DWAIT when dwait.
  - DWAIT→RUN when ~dwait.
  - In DWAIT, wait_cnt increments each cycle. It resets to 0 on leaving DWAIT.
  - In DWAIT with wait_cnt==DWAIT_MAX-1 and dwait: go to ERR and set timeout_err=1.
  - dmem_ack on the same cycle as the limit wins: no error, go to RUN.
- wait_cnt saturates and never wraps.
- Reset mid-DWAIT or in ERR: returns to RUN next edge and clears all flags.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds output ports perf_dstall, perf_istall, perf_hstall (CNT_W each).
  - Saturating counts of rule-2, rule-5 and rule-3 cycles.
  - Cleared by reset; frozen in ERR.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - enum pipe_state_e {RUN, DWAIT, ERR}
  - struct pipe_ctrl_t bundling the five enables and three clears
  - default DWAIT_MAX constant
- One natural sub-module, pipe_wdog: wait counter plus limit compare. It exposes expire and is instantiated once.

Test Plan:
- Reset: rst_n=0 for 2 cycles while dmem_req_M=1, dmem_ack=0 → after release state=RUN, halted=0, timeout_err=0, then DWAIT entered next cycle.
- D-mem wait: dmem_req_M=1, dmem_ack=0 for 3 cycles then ack → en_F..en_M=0 and clr_W=1 for 3 cycles, all en=1 on the ack cycle.
- Load-use: hz_stallD=hz_stallF=hz_flushE=1 for 1 cycle → en_F=en_D=0, clr_E=1, en_M=en_W=1. Same inputs with dwait → rule 2 outputs only.
- Kill: br_en_E=1, hz_flushD=hz_flushE=1, imem_valid=0 for 2 cycles, then imem_valid=1 → kill_pending=1, clr_D=1 on the valid cycle, next valid cycle clr_D=0.
- Watchdog: DWAIT_MAX=4, dmem_ack held 0 → ERR on 4th wait edge, halted=timeout_err=1, all en=0. With a second run, dmem_ack=1 on the 4th cycle → RUN, no error.
- PIPE_CTRL_PERF_EN: 5 D-mem wait cycles, 2 fetch-wait cycles, 1 load-use cycle → perf_dstall=5, perf_istall=2, perf_hstall=1.
